eth_tx_arb: RTL and testbench
=============================

// Module: eth_tx_arb
// PURPOSE
//   Two-requester round-robin arbiter and sequencer for the shared RMII transmit byte path.
//   Grants one requester a whole frame (e.g. ARP responder vs. UDP app) and passes its byte stream.
//   Enforces an inter-frame gap before the next grant is issued.
//   Sits between frame sources and the transmit byte serializer/CRC appender.
// PARAMETERS
//   pIFG_CYCLES  48    idle Clk cycles after a frame's last byte (12 bytes x 4 dibits at RMII)
//   pMAX_BYTES   1518  watchdog frame length limit in bytes (used only with ETH_TX_ARB_WDOG_EN)
// PORTS
//   Clk          in   1  50 MHz RMII reference clock
//   Rst          in   1  asynchronous, active-high reset
//   Req0_Vld     in   1  requester 0 byte valid; a rising Vld in IDLE is a frame request
//   Req0_Data    in   8  requester 0 byte
//   Req0_Last    in   1  requester 0 final byte of frame
//   Req0_Rdy     out  1  requester 0 byte accepted this cycle
//   Req1_Vld/Req1_Data/Req1_Last/Req1_Rdy  as requester 0, for requester 1
//   Tx_Vld       out  1  byte valid toward serializer
//   Tx_Data      out  8  granted byte
//   Tx_Last      out  1  final byte of frame
//   Tx_Rdy       in   1  serializer accepts byte (transfer = Tx_Vld & Tx_Rdy)
//   Grant        out  2  one-hot current owner; 00 when none
//   Busy         out  1  state != IDLE
//   Abort        out  1  one-cycle pulse: frame truncated by watchdog
// BEHAVIOUR
//   - Reset values: state IDLE, Grant=00, Tx_Vld=0, Tx_Last=0, Tx_Data=00, ReqN_Rdy=0, Busy=0,
//     Abort=0, RR pointer=req0, IFG count=0, byte count=0. Reset mid-frame clears immediately.
//   - States: IDLE -> XFER -> IFG -> IDLE, plus DRAIN (watchdog only).
//   - IDLE: one or more ReqN_Vld high -> register Grant next edge and enter XFER.
//     Single request: that requester wins.
//     Both requesting: the RR pointer requester wins.
//   - Grant latency: 1 cycle from Vld to Grant. No bytes are accepted in the IDLE cycle.
//   - XFER: combinational pass-through from the granted requester g:
//     Tx_Vld=Reqg_Vld, Tx_Data=Reqg_Data, Tx_Last=Reqg_Last, Reqg_Rdy=Tx_Rdy.
//     The non-granted requester sees Rdy=0.
//     A Vld drop mid-frame is a bubble. Grant is held, no timeout.
//   - Transfer with Tx_Last=1 in XFER: enter IFG and set the RR pointer to the other requester.
//     Grant clears on the same edge.
//   - IFG: count pIFG_CYCLES cycles with all Rdy=0 and Tx_Vld=0, then IDLE.
//     With pIFG_CYCLES=0, go directly to IDLE.
//     Requests arriving during IFG wait; arbitration happens in IDLE.
//   - Back-to-back frames alternate owners when both requesters hold Vld. Neither can starve.
//   - Tx_Data is don't-care when Tx_Vld=0, but is driven 00 outside XFER.
// CONFIGURATION
//   ETH_TX_ARB_WDOG_EN defined:
//     - An 11-bit saturating byte counter counts transfers in XFER and clears on entry to XFER.
//     - When the pMAX_BYTES-th byte transfers without Reqg_Last, Tx_Last is forced to 1 on that byte.
//     - Abort pulses on the same cycle and the state moves to DRAIN.
//     - DRAIN: Reqg_Rdy=1 and Tx_Vld=0. Requester bytes are discarded until Reqg_Last is seen with Vld.
//       Then IFG, with the pointer advanced as normal.
//   ETH_TX_ARB_WDOG_EN undefined:
//     - No counter and no DRAIN state; Abort is tied 0.
//     - Frames are unlimited; pMAX_BYTES is ignored.
// TESTING
//   1 Reset: assert Rst with Req0_Vld=1 -> Grant=00, Tx_Vld=0, Busy=0 while Rst high.
//     Grant=01 one cycle after release.
//   2 Single frame: Req0 sends 64 bytes (0x00..0x3F) with Tx_Rdy=1.
//     -> Tx_Data matches in order, Tx_Last on 0x3F, Grant=00 next cycle.
//     -> 48 idle cycles, then IDLE.
//   3 Contention: Req0 and Req1 Vld together, each with 3 frames.
//     -> grant order 0,1,0,1,0,1 with an IFG between every frame.
//   4 Backpressure/bubbles: toggle Tx_Rdy 50% and drop Req1_Vld for 5 cycles mid-frame.
//     -> no byte lost or duplicated, Grant held, Req0_Rdy=0 throughout.
//   5 Reset mid-frame: Rst at byte 20 of Req1's frame -> all outputs at reset values same cycle.
//     Next arbitration favours req0.
//   6 WDOG_EN: pMAX_BYTES=16, Req0 sends 40 bytes.
//     -> Tx_Last and Abort on byte 16, bytes 17..40 absorbed with Tx_Vld=0.
//     -> IFG after byte 40's Last.
//     Same stimulus without the macro -> 40 bytes pass and Abort stays 0.

Source files
------------

// File: rtl/eth_tx_arb.sv
// eth_tx_arb: round-robin arbiter granting whole frames from two sources onto the RMII transmit byte path.
// Optional byte-count watchdog with frame truncation is enabled by defining ETH_TX_ARB_WDOG_EN.
module eth_tx_arb #(
    parameter int pIFG_CYCLES = 48,
    parameter int pMAX_BYTES  = 1518
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Req0_Vld,
    input  logic [7:0] Req0_Data,
    input  logic       Req0_Last,
    output logic       Req0_Rdy,
    input  logic       Req1_Vld,
    input  logic [7:0] Req1_Data,
    input  logic       Req1_Last,
    output logic       Req1_Rdy,
    output logic       Tx_Vld,
    output logic [7:0] Tx_Data,
    output logic       Tx_Last,
    input  logic       Tx_Rdy,
    output logic [1:0] Grant,
    output logic       Busy,
    output logic       Abort
);
    localparam int IW = (pIFG_CYCLES > 1) ? $clog2(pIFG_CYCLES) : 1;

    if (pMAX_BYTES < 1 || pMAX_BYTES > 2047) begin : g_bad_max
        $error("pMAX_BYTES must fit the 11-bit byte counter");
    end

`ifdef ETH_TX_ARB_WDOG_EN
    typedef enum logic [1:0] {IDLE, XFER, IFG, DRAIN} state_t;
    logic [10:0] cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {IDLE, XFER, IFG} state_t;
`endif
    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          ptr_q, ptr_d;
    logic [IW-1:0] ifg_q, ifg_d;
    logic          sel, src_vld, src_last, src_rdy, end_frame;
    logic [7:0]    src_data;

    assign sel      = grant_q[1];
    assign src_vld  = sel ? Req1_Vld : Req0_Vld;
    assign src_data = sel ? Req1_Data : Req0_Data;
    assign src_last = sel ? Req1_Last : Req0_Last;
    assign Req0_Rdy = src_rdy & ~sel;
    assign Req1_Rdy = src_rdy & sel;
    assign Grant    = grant_q;
    assign Busy     = state_q != IDLE;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        ifg_d     = ifg_q;
        Tx_Vld    = 1'b0;
        Tx_Data   = 8'h00;
        Tx_Last   = 1'b0;
        Abort     = 1'b0;
        src_rdy   = 1'b0;
        end_frame = 1'b0;
`ifdef ETH_TX_ARB_WDOG_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (Req0_Vld | Req1_Vld) begin
                    grant_d = (Req1_Vld & (~Req0_Vld | ptr_q)) ? 2'b10 : 2'b01;
                    state_d = XFER;
`ifdef ETH_TX_ARB_WDOG_EN
                    cnt_d   = 11'd0;
`endif
                end
            end
            XFER: begin
                Tx_Vld  = src_vld;
                Tx_Data = src_data;
                Tx_Last = src_last;
                src_rdy = Tx_Rdy;
                if (src_vld & Tx_Rdy) begin
`ifdef ETH_TX_ARB_WDOG_EN
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 11'd1;
                    if (src_last) begin
                        end_frame = 1'b1;
                    end else if (cnt_q == 11'(pMAX_BYTES - 1)) begin
                        // truncate: this byte closes the frame downstream, the rest is drained
                        Tx_Last = 1'b1;
                        Abort   = 1'b1;
                        state_d = DRAIN;
                    end
`else
                    end_frame = src_last;
`endif
                end
            end
            IFG: begin
                ifg_d = ifg_q + 1'b1;
                if (ifg_q == IW'(pIFG_CYCLES - 1)) state_d = IDLE;
            end
`ifdef ETH_TX_ARB_WDOG_EN
            DRAIN: begin
                src_rdy   = 1'b1;
                end_frame = src_vld & src_last;
            end
`endif
            default: state_d = IDLE;
        endcase
        if (end_frame) begin
            grant_d = 2'b00;
            ptr_d   = ~sel;
            ifg_d   = '0;
            state_d = (pIFG_CYCLES == 0) ? IDLE : IFG;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            ptr_q   <= 1'b0;
            ifg_q   <= '0;
`ifdef ETH_TX_ARB_WDOG_EN
            cnt_q   <= 11'd0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            ifg_q   <= ifg_d;
`ifdef ETH_TX_ARB_WDOG_EN
            cnt_q   <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_eth_tx_arb.sv
// tb_eth_tx_arb: directed vectors and frame-level sequences for eth_tx_arb.
// Byte limit 16 is only exercised when ETH_TX_ARB_WDOG_EN is defined.
module tb_eth_tx_arb;
`ifdef ETH_TX_ARB_WDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif
    localparam int IFG = 48;
    localparam int L2  = WD ? 16 : 64;
    localparam int L4  = WD ? 16 : 30;
    localparam int BI  = WD ? 8 : 20;
    localparam int RB  = WD ? 10 : 20;

    logic       Clk = 1'b0, Rst = 1'b1;
    logic       Req0_Vld = 1'b1, Req0_Last = 1'b0, Req1_Vld = 1'b0, Req1_Last = 1'b0, Tx_Rdy = 1'b1;
    logic [7:0] Req0_Data = 8'h00, Req1_Data = 8'h00;
    logic       Req0_Rdy, Req1_Rdy, Tx_Vld, Tx_Last, Busy, Abort;
    logic [7:0] Tx_Data;
    logic [1:0] Grant;
    int         checks = 0, errors = 0, ptr_m = 0;

    eth_tx_arb #(.pIFG_CYCLES(IFG), .pMAX_BYTES(16)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req0_Vld(Req0_Vld), .Req0_Data(Req0_Data), .Req0_Last(Req0_Last), .Req0_Rdy(Req0_Rdy),
        .Req1_Vld(Req1_Vld), .Req1_Data(Req1_Data), .Req1_Last(Req1_Last), .Req1_Rdy(Req1_Rdy),
        .Tx_Vld(Tx_Vld), .Tx_Data(Tx_Data), .Tx_Last(Tx_Last), .Tx_Rdy(Tx_Rdy),
        .Grant(Grant), .Busy(Busy), .Abort(Abort)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic v0; logic [7:0] d0; logic l0;
        logic v1; logic [7:0] d1; logic l1;
        logic rdy;
        logic [14:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dat(input int n, input int i);
        return {n[0], i[6:0]};
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        {Req0_Vld, Req0_Last, Req1_Vld, Req1_Last} = '0;
        @(negedge Clk);
        Rst = 1'b0;
        ptr_m = 0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 200; c++) begin
            @(negedge Clk);
            #1;
            if (!Busy) break;
        end
        chk("idle_reached", Busy, 0);
    endtask

    // frame-level model: owner choice, byte order, gap length and quiet outputs between frames
    task automatic traffic(input int nf0, input int nf1, input int len, input bit bp);
        int idx[2], done[2], owner, gap, bub, w;
        bit in_gap, bubble;
        logic vld;
        idx[0] = 0; idx[1] = 0; done[0] = 0; done[1] = 0;
        owner = -1; gap = 0; bub = 0; in_gap = 0;
        for (int c = 0; c < 5000 && (done[0] < nf0 || done[1] < nf1 || owner >= 0 || in_gap); c++) begin
            @(negedge Clk);
            Tx_Rdy    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            bubble    = bp && owner == 1 && idx[1] == BI && bub < 5;
            if (bubble) bub++;
            Req0_Vld  = done[0] < nf0;
            Req0_Data = dat(0, idx[0]);
            Req0_Last = idx[0] == len - 1;
            Req1_Vld  = (done[1] < nf1) && !bubble;
            Req1_Data = dat(1, idx[1]);
            Req1_Last = idx[1] == len - 1;
            #1;
            if (in_gap) begin
                if (Busy) begin
                    gap++;
                    chk("ifg_quiet", {Grant, Tx_Vld, Req0_Rdy, Req1_Rdy}, 0);
                end else begin
                    chk("ifg_len", gap, IFG);
                    in_gap = 0;
                end
            end
            if (owner < 0 && !in_gap) begin
                if (Grant != 2'b00) begin
                    w = (done[0] < nf0 && done[1] < nf1) ? ptr_m : (done[1] < nf1 ? 1 : 0);
                    chk("grant_win", Grant, 2'b01 << w);
                    owner = w;
                end else begin
                    chk("idle_quiet", {Tx_Vld, Req0_Rdy, Req1_Rdy}, 0);
                end
            end
            if (owner >= 0) begin
                vld = owner == 1 ? Req1_Vld : Req0_Vld;
                chk("grant_hold", Grant, 2'b01 << owner);
                chk("other_rdy", owner == 1 ? Req0_Rdy : Req1_Rdy, 0);
                chk("own_rdy", owner == 1 ? Req1_Rdy : Req0_Rdy, Tx_Rdy);
                chk("tx_vld", Tx_Vld, vld);
                if (vld) begin
                    chk("tx_data", Tx_Data, dat(owner, idx[owner]));
                    chk("tx_last", Tx_Last, idx[owner] == len - 1);
                end
                if (vld && Tx_Rdy) begin
                    if (idx[owner] == len - 1) begin
                        idx[owner] = 0;
                        done[owner]++;
                        ptr_m  = 1 - owner;
                        owner  = -1;
                        in_gap = 1;
                        gap    = 0;
                    end else begin
                        idx[owner]++;
                    end
                end
            end
        end
        chk("traffic_end", 32'(done[0] < nf0 || done[1] < nf1 || owner >= 0 || in_gap), 0);
        {Req0_Vld, Req1_Vld, Req0_Last, Req1_Last} = '0;
    endtask

    initial begin
        vec_t tv[5];
        int i;
        // reset held with a request pending, then one-cycle grant latency
        @(negedge Clk);
        #1;
        chk("rst_grant", Grant, 0);
        chk("rst_txvld", Tx_Vld, 0);
        chk("rst_busy", Busy, 0);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        chk("idle_no_accept", {Grant, Req0_Rdy}, 0);
        @(negedge Clk);
        #1;
        chk("grant_latency", Grant, 2'b01);

        do_reset();
        tv[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0}};
        tv[1] = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, {1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1}};
        tv[2] = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, {1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1}};
        tv[3] = '{1'b1, 8'h12, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, {1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1}};
        tv[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1}};
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            {Req0_Vld, Req0_Data, Req0_Last} = {tv[k].v0, tv[k].d0, tv[k].l0};
            {Req1_Vld, Req1_Data, Req1_Last} = {tv[k].v1, tv[k].d1, tv[k].l1};
            Tx_Rdy = tv[k].rdy;
            #1;
            chk($sformatf("vec%0d", k), {Tx_Vld, Tx_Data, Tx_Last, Req0_Rdy, Req1_Rdy, Grant, Busy}, tv[k].exp);
        end
        wait_idle();
        ptr_m = 1;

        traffic(1, 0, L2, 1'b0);
        do_reset();
        traffic(3, 3, 4, 1'b0);
        traffic(0, 1, L4, 1'b1);

        // reset in the middle of a req1 frame while the pointer favours req1
        traffic(1, 0, 8, 1'b0);
        i = 0;
        for (int c = 0; c < 200 && i < RB; c++) begin
            @(negedge Clk);
            Tx_Rdy    = 1'b1;
            Req1_Vld  = 1'b1;
            Req1_Data = dat(1, i);
            Req1_Last = 1'b0;
            #1;
            if (Req1_Rdy) i++;
        end
        @(negedge Clk);
        Req1_Data = dat(1, i);
        #1;
        chk("pre_rst_grant", Grant, 2'b10);
        Rst = 1'b1;
        #1;
        chk("rst_mid", {Grant, Tx_Vld, Tx_Last, Tx_Data, Req0_Rdy, Req1_Rdy, Busy, Abort}, 0);
        Req0_Vld = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        #1;
        chk("rr_after_rst", Grant, 2'b01);
        do_reset();

        // 40-byte frame against a 16-byte limit (limit only active with the watchdog built in)
        i = 0;
        for (int c = 0; c < 300 && i < 40; c++) begin
            @(negedge Clk);
            Tx_Rdy    = 1'b1;
            Req0_Vld  = 1'b1;
            Req0_Data = dat(0, i);
            Req0_Last = i == 39;
            #1;
            if (Req0_Rdy) begin
                chk($sformatf("wd_byte%0d", i), {Tx_Vld, Tx_Last, Abort},
                    {1'(!WD || i < 16), 1'(WD ? i == 15 : i == 39), 1'(WD && i == 15)});
                if (Tx_Vld) chk("wd_data", Tx_Data, dat(0, i));
                i++;
            end else begin
                chk("wd_abort_idle", Abort, 0);
            end
        end
        @(negedge Clk);
        Req0_Vld  = 1'b0;
        Req0_Last = 1'b0;
        #1;
        chk("wd_bytes", i, 40);
        chk("wd_ifg", {Grant, Busy, Abort}, 4'b0010);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
